cacheline_adapter: RTL
======================

Name: cacheline_adapter

Overview:
Memory-side responder for the cache DFP read/write handshake. It serves one full cache line per request by running a multi-beat burst on the banked burst-memory interface. It sits between the icache/dcache DFP ports (initiators) and burst memory. Read beats are assembled into a line; write lines are split into beats. dfp_resp pulses once per completed transaction.

Parameters:
ADDR_W, 32, byte address width.
LINE_W, 256, cache line width in bits.
BEAT_W, 64, burst-memory beat width in bits.
BEATS is a derived localparam equal to LINE_W/BEAT_W (default 4). OFF_W is a derived localparam equal to log2(LINE_W/8) (default 5).

Ports:
clk  in  1  clock
rst  in  1  reset
dfp_addr  in  ADDR_W  line request address
dfp_read  in  1  line read request, held until dfp_resp
dfp_write  in  1  line write request, held until dfp_resp
dfp_wdata  in  LINE_W  write line
dfp_rdata  out  LINE_W  assembled read line
dfp_resp  out  1  one-cycle completion pulse
bmem_addr  out  ADDR_W  burst address, line aligned
bmem_read  out  1  burst read command
bmem_write  out  1  write beat valid
bmem_wdata  out  BEAT_W  write beat
bmem_ready  in  1  memory accepts command or beat this cycle
bmem_raddr  in  ADDR_W  address tag of returning read beat
bmem_rdata  in  BEAT_W  read beat
bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset: rst is synchronous and active-high, on clk. On reset the state is IDLE, the beat counter is 0, and dfp_rdata is 0. All bmem_* command outputs are 0 and dfp_resp is 0. Reset mid-transaction abandons the transaction with no response. Beats arriving after reset are ignored unless they match a new read in RD_DATA.
- Latched address = dfp_addr with its low OFF_W bits cleared. bmem_addr is driven from the latch only and is 0 when in IDLE.
- IDLE:
  - If dfp_write is high, latch the address and dfp_wdata, clear the counter, and go to WR.
  - Else if dfp_read is high, latch the address, clear the counter, and go to RD_REQ.
  - If both are high, write has priority; this is a protocol error for the requester.
- RD_REQ: bmem_read = 1. On bmem_ready, go to RD_DATA; otherwise stay and hold the command.
- RD_DATA:
  - Each cycle with bmem_rvalid=1 and bmem_raddr equal to the latched address, write bmem_rdata into dfp_rdata bits [cnt*BEAT_W +: BEAT_W] and increment cnt.
  - Beats with a mismatched raddr, or any rvalid outside RD_DATA, are ignored.
  - When the beat with cnt==BEATS-1 is accepted, go to RESP.
- WR:
  - bmem_write = 1 and bmem_wdata = latched line beat[cnt].
  - On bmem_ready, increment cnt. When the beat with cnt==BEATS-1 is accepted, go to RESP.
  - Gaps in bmem_ready stall with outputs held stable.
- RESP: dfp_resp = 1 for exactly one cycle, then go to IDLE. No request is sampled in RESP.
- dfp_rdata holds its value after RESP until the next read overwrites beats. It is valid in the RESP cycle.
- Latency:
  - Read with bmem_ready=1 and beats arriving back-to-back starting in the cycle after command acceptance: request seen in cycle 0, command in cycle 1, beats in cycles 2..5, dfp_resp in cycle 6.
  - Write with ready always high: dfp_resp in cycle 1+BEATS+0, i.e. beats in cycles 1..4 and resp in cycle 5.
- Counter width is log2(BEATS). It is cleared on entry to RD_REQ and WR.
- Single outstanding transaction only. A request held high across RESP is re-accepted in IDLE on the following cycle.

Test Plan:
- Read at dfp_addr=0x1234_5678, ready=1, beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> bmem_addr=0x1234_5660; dfp_resp pulses one cycle in cycle 6; dfp_rdata = {beat3,beat2,beat1,beat0}.
- Read with bmem_ready low for 3 cycles and one-cycle gaps between beats -> bmem_read is held stable until ready; a single resp occurs after the 4th beat, and the line is correct.
- Write of a 256-bit line at 0x0000_1040 with bmem_ready toggling 1,0,1,0,... -> beats are issued in order 0..3, each stable while unaccepted; dfp_resp comes exactly once after the 4th acceptance.
- During RD_DATA, a beat with bmem_raddr=0xDEAD_BEE0 -> ignored, cnt unchanged, and the final line has no corruption.
- rst asserted after 2 read beats, then a new read to a different address -> no dfp_resp for the aborted read; the new read returns only new-address beats correctly.
- dfp_read and dfp_write both high -> write is performed (bmem_write asserted, no bmem_read); dfp_read held across RESP -> a new RD_REQ starts in the cycle after the IDLE re-sample.

Source files
------------

// File: rtl/cacheline_adapter.sv
// cacheline_adapter
// -----------------
// Memory-side responder for the cache DFP line handshake. Each accepted
// request is served as one multi-beat burst on the burst-memory interface:
// read beats are assembled into a full line, write lines are split into
// beats. dfp_resp pulses for one cycle when the transaction completes.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   dfp_addr      line request address (low offset bits are ignored)
//   dfp_read      line read request, held until dfp_resp
//   dfp_write     line write request, held until dfp_resp (wins over read)
//   dfp_wdata     line to be written
//   dfp_rdata     assembled read line, valid in the dfp_resp cycle and held
//   dfp_resp      one-cycle completion pulse
//   bmem_addr     line-aligned burst address (0 while idle)
//   bmem_read     burst read command, held until bmem_ready
//   bmem_write    write beat valid
//   bmem_wdata    write beat, held stable until bmem_ready
//   bmem_ready    memory accepts the command or beat this cycle
//   bmem_raddr    address tag of the returning read beat
//   bmem_rdata    read beat
//   bmem_rvalid   read beat valid
module cacheline_adapter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR,
    RESP
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]             cnt;
  logic [ADDR_W-1:0]            addr_q;
  logic [BEATS-1:0][BEAT_W-1:0] wline_q;
  logic [BEATS-1:0][BEAT_W-1:0] rline_q;

  logic start_wr;
  logic start_rd;
  logic rd_accept;
  logic wr_accept;
  logic rd_hit;
  logic last_beat;
  logic [ADDR_W-1:0] aligned_addr;

  assign aligned_addr = {dfp_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign last_beat    = (cnt == LAST_BEAT);
  // Beats tagged with another address belong to some other burst (e.g. one
  // abandoned by reset) and must never land in this line.
  assign rd_hit       = bmem_rvalid && (bmem_raddr == addr_q);

  // Next-state logic. Write is checked before read so a requester that
  // raises both gets a write. RESP never samples requests, so a request
  // held across RESP is picked up again by IDLE one cycle later.
  always_comb begin
    state_n   = state;
    start_wr  = 1'b0;
    start_rd  = 1'b0;
    rd_accept = 1'b0;
    wr_accept = 1'b0;
    case (state)
      IDLE: begin
        if (dfp_write) begin
          start_wr = 1'b1;
          state_n  = WR;
        end else if (dfp_read) begin
          start_rd = 1'b1;
          state_n  = RD_REQ;
        end
      end
      RD_REQ: begin
        if (bmem_ready) begin
          state_n = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rd_hit) begin
          rd_accept = 1'b1;
          if (last_beat) begin
            state_n = RESP;
          end
        end
      end
      WR: begin
        if (bmem_ready) begin
          wr_accept = 1'b1;
          if (last_beat) begin
            state_n = RESP;
          end
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers. The line buffers only change on a new
  // request (write line) or an accepted beat (read line), so dfp_rdata
  // keeps the last read line until another read overwrites it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state <= state_n;
      if (start_wr || start_rd) begin
        addr_q <= aligned_addr;
        cnt    <= '0;
      end
      if (start_wr) begin
        wline_q <= dfp_wdata;
      end
      if (rd_accept) begin
        rline_q[cnt] <= bmem_rdata;
        cnt          <= cnt + CNT_W'(1);
      end
      if (wr_accept) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Outputs are a function of state and registers only, so a stalled beat
  // or command stays stable until memory accepts it.
  assign dfp_rdata  = rline_q;
  assign dfp_resp   = (state == RESP);
  assign bmem_read  = (state == RD_REQ);
  assign bmem_write = (state == WR);
  assign bmem_wdata = (state == WR) ? wline_q[cnt] : '0;
  assign bmem_addr  = (state == IDLE) ? '0 : addr_q;

endmodule
